// File: rtl/sakebi_eth_frame_tx.sv
// Ethernet framing stage ahead of the RMII transmitter: pads short frames, appends
// the CRC-32 FCS and paces bytes to one per line-byte slot, then holds off for the IFG.
module sakebi_eth_frame_tx #(
  parameter int DATA_WIDTH      = 8,
  parameter int CYCLES_PER_BYTE = 8,
  parameter int MIN_LEN         = 60,
  parameter int IFG_BYTES       = 12
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_s_axis_TVALID,
  output logic                  o_s_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s_axis_TDATA,
  input  logic                  i_s_axis_TLAST,
  output logic                  o_m_axis_TVALID,
  input  logic                  i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
  output logic                  o_underrun,
  output logic                  o_busy
);

  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam logic [PW-1:0] PACE_LAST = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [15:0]   IFG_LAST  = 16'((IFG_BYTES > 0) ? IFG_BYTES - 1 : 0);
  localparam logic [31:0]   CRC_INIT  = 32'hFFFF_FFFF;

  // Handshake contract: a byte moves on either port only in a cycle where VALID and
  // READY are both high; o_m_axis_TVALID/TDATA never change while stalled.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_PAD     = 3'd2,
    S_FCS     = 3'd3,
    S_DISCARD = 3'd4,
    S_IFG     = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_pace;
  logic [31:0]           r_crc;
  logic [10:0]           r_cnt;
  logic [1:0]            r_fcs_idx;
  logic [15:0]           r_ifg_cnt;
  logic                  r_bad;
  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_underrun;

  logic                  w_slot;
  logic                  w_s_tready;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_crc_upd;
  logic                  w_cnt_inc;
  logic                  w_clr_frame;
  logic                  w_set_bad;
  logic                  w_clr_bad;
  logic                  w_underrun;
  logic [10:0]           w_cnt_sat;
  logic [31:0]           w_fcs_word;
  logic [7:0]            w_fcs_byte;
  logic [31:0]           w_crc_nxt;

  // Reflected CRC-32, one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_slot     = (r_pace == PACE_LAST) && (!r_tvalid || i_m_axis_TREADY);
  assign w_cnt_sat  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
  assign w_fcs_word = r_bad ? r_crc : ~r_crc;
  assign w_crc_nxt  = crc32_byte(r_crc, w_load_data);

  always_comb begin
    w_fcs_byte = w_fcs_word[7:0];
    case (r_fcs_idx)
      2'd1:    w_fcs_byte = w_fcs_word[15:8];
      2'd2:    w_fcs_byte = w_fcs_word[23:16];
      2'd3:    w_fcs_byte = w_fcs_word[31:24];
      default: w_fcs_byte = w_fcs_word[7:0];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_tready  = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_crc_upd   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_clr_frame = 1'b0;
    w_set_bad   = 1'b0;
    w_clr_bad   = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_s_axis_TVALID) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_s_tready = w_slot && i_s_axis_TVALID;
        if (w_s_tready) begin
          w_load      = 1'b1;
          w_load_data = i_s_axis_TDATA;
          w_crc_upd   = 1'b1;
          w_cnt_inc   = 1'b1;
          if (i_s_axis_TLAST) begin
            w_state_nxt = (int'(w_cnt_sat) < MIN_LEN) ? S_PAD : S_FCS;
          end
        end else if (w_slot) begin
          // Starved slot: the line would see a hole, so poison the frame instead.
          w_underrun  = 1'b1;
          w_set_bad   = 1'b1;
          w_state_nxt = S_FCS;
        end
      end
      S_PAD: begin
        if (w_slot) begin
          w_load    = 1'b1;
          w_crc_upd = 1'b1;
          w_cnt_inc = 1'b1;
          if (int'(w_cnt_sat) >= MIN_LEN) w_state_nxt = S_FCS;
        end
      end
      S_FCS: begin
        if (w_slot) begin
          w_load      = 1'b1;
          w_load_data = w_fcs_byte;
          if (r_fcs_idx == 2'd3) begin
            w_clr_frame = 1'b1;
            w_state_nxt = r_bad ? S_DISCARD : S_IFG;
          end
        end
      end
      S_DISCARD: begin
        w_s_tready = 1'b1;
        if (i_s_axis_TVALID && i_s_axis_TLAST) begin
          w_clr_bad   = 1'b1;
          w_state_nxt = S_IFG;
        end
      end
      S_IFG: begin
        if (IFG_BYTES == 0) begin
          w_state_nxt = S_IDLE;
        end else if (w_slot && (r_ifg_cnt == IFG_LAST)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pace counter stops at the terminal count until the output register can take a byte.
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      r_pace <= '0;
    end else if (r_state == S_IDLE) begin
      r_pace <= '0;
    end else if (r_pace != PACE_LAST) begin
      r_pace <= r_pace + 1'b1;
    end else if (w_slot) begin
      r_pace <= '0;
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      r_crc     <= CRC_INIT;
      r_cnt     <= '0;
      r_fcs_idx <= '0;
      r_ifg_cnt <= '0;
      r_bad     <= 1'b0;
    end else begin
      if (w_clr_frame) begin
        r_crc <= CRC_INIT;
        r_cnt <= '0;
      end else begin
        if (w_crc_upd) r_crc <= w_crc_nxt;
        if (w_cnt_inc) r_cnt <= w_cnt_sat;
      end
      if (r_state != S_FCS) begin
        r_fcs_idx <= '0;
      end else if (w_slot) begin
        r_fcs_idx <= r_fcs_idx + 2'd1;
      end
      if (r_state != S_IFG) begin
        r_ifg_cnt <= '0;
      end else if (w_slot) begin
        r_ifg_cnt <= r_ifg_cnt + 16'd1;
      end
      if (w_set_bad) begin
        r_bad <= 1'b1;
      end else if (w_clr_bad) begin
        r_bad <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_load_data;
      end else if (i_m_axis_TREADY) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_s_axis_TREADY = w_s_tready;
  assign o_m_axis_TVALID = r_tvalid;
  assign o_m_axis_TDATA  = r_tdata;
  assign o_underrun      = r_underrun;
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sakebi_eth_frame_tx.sv
// Directed bench for sakebi_eth_frame_tx: one padded instance (MIN_LEN=60) and one
// unpadded instance (MIN_LEN=0) driven from a single linear sequence.
module tb_sakebi_eth_frame_tx;

  localparam int CPB = 8;
  localparam int IFG = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_s_tvalid, a_s_tready, a_s_tlast, a_m_tvalid, a_m_tready, a_underrun, a_busy;
  logic [7:0] a_s_tdata, a_m_tdata;
  logic       b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_underrun, b_busy;
  logic [7:0] b_s_tdata, b_m_tdata;

  sakebi_eth_frame_tx #(.DATA_WIDTH(8), .CYCLES_PER_BYTE(CPB), .MIN_LEN(60), .IFG_BYTES(IFG)) u_a (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_s_axis_TVALID(a_s_tvalid), .o_s_axis_TREADY(a_s_tready),
    .i_s_axis_TDATA(a_s_tdata), .i_s_axis_TLAST(a_s_tlast),
    .o_m_axis_TVALID(a_m_tvalid), .i_m_axis_TREADY(a_m_tready),
    .o_m_axis_TDATA(a_m_tdata), .o_underrun(a_underrun), .o_busy(a_busy));

  sakebi_eth_frame_tx #(.DATA_WIDTH(8), .CYCLES_PER_BYTE(CPB), .MIN_LEN(0), .IFG_BYTES(IFG)) u_b (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_s_axis_TVALID(b_s_tvalid), .o_s_axis_TREADY(b_s_tready),
    .i_s_axis_TDATA(b_s_tdata), .i_s_axis_TLAST(b_s_tlast),
    .o_m_axis_TVALID(b_m_tvalid), .i_m_axis_TREADY(b_m_tready),
    .o_m_axis_TDATA(b_m_tdata), .o_underrun(b_underrun), .o_busy(b_busy));

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  bit abort_tx = 1'b0;

  logic [7:0]  frm_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  a_got_q[$], b_got_q[$];
  int unsigned a_tim_q[$], b_tim_q[$];
  int          a_under_cnt = 0, b_under_cnt = 0;
  int          a_stab_err = 0, a_hold_cycles = 0;
  logic        a_hold = 1'b0;
  logic [7:0]  a_hold_d = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitors sample on the falling edge, half a cycle clear of the DUT's edge.
  always @(negedge clk) begin
    if (a_m_tvalid && a_m_tready) begin
      a_got_q.push_back(a_m_tdata);
      a_tim_q.push_back(cyc);
    end
    if (b_m_tvalid && b_m_tready) begin
      b_got_q.push_back(b_m_tdata);
      b_tim_q.push_back(cyc);
    end
    if (a_underrun) a_under_cnt++;
    if (b_underrun) b_under_cnt++;
    if (a_hold && (!a_m_tvalid || a_m_tdata != a_hold_d)) a_stab_err++;
    if (a_m_tvalid && !a_m_tready) a_hold_cycles++;
    a_hold   = a_m_tvalid && !a_m_tready;
    a_hold_d = a_m_tdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Appends the expected line bytes for frm_q. cut<0: good frame; else only the first
  // cut bytes go out, followed by the complemented FCS.
  task automatic add_expected(input int min_len, input int cut);
    logic [31:0] c;
    logic [31:0] fcs;
    int n;
    int lim;
    c = 32'hFFFF_FFFF;
    n = 0;
    lim = (cut < 0) ? frm_q.size() : cut;
    for (int i = 0; i < lim; i++) begin
      exp_q.push_back(frm_q[i]);
      c = crc_step(c, frm_q[i]);
      n++;
    end
    if (cut < 0) begin
      while (n < min_len) begin
        exp_q.push_back(8'h00);
        c = crc_step(c, 8'h00);
        n++;
      end
    end
    fcs = (cut < 0) ? ~c : c;
    exp_q.push_back(fcs[7:0]);
    exp_q.push_back(fcs[15:8]);
    exp_q.push_back(fcs[23:16]);
    exp_q.push_back(fcs[31:24]);
  endtask

  task automatic make_frame(input int n);
    frm_q.delete();
    for (int i = 0; i < n; i++) frm_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      a_s_tvalid = v; a_s_tdata = d; a_s_tlast = l;
    end else begin
      b_s_tvalid = v; b_s_tdata = d; b_s_tlast = l;
    end
  endtask

  // Presents frm_q byte by byte; drop_after>=0 idles TVALID for one slot before that byte.
  task automatic send_frame(input int sel, input int drop_after);
    for (int i = 0; i < frm_q.size(); i++) begin
      int guard;
      bit acc;
      guard = 0;
      acc = 1'b0;
      if (i == drop_after) begin
        drive(sel, 1'b0, 8'h00, 1'b0);
        repeat (CPB) @(posedge clk);
        #1;
      end
      drive(sel, 1'b1, frm_q[i], (i == frm_q.size() - 1));
      while (!acc && !abort_tx && guard < 3000) begin
        @(negedge clk);
        acc = (sel == 0) ? a_s_tready : b_s_tready;
        guard++;
      end
      if (!acc && !abort_tx) begin
        checks++;
        errors++;
        $error("FAIL tx_timeout: byte %0d observed=not accepted expected=accepted", i);
        abort_tx = 1'b1;
      end
      @(posedge clk);
      #1;
      if (abort_tx) break;
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input int sel, input string tag);
    int guard;
    guard = 0;
    repeat (2) @(negedge clk);
    while (((sel == 0) ? a_busy : b_busy) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_idle"}, 32'((sel == 0) ? a_busy : b_busy), 32'd0);
  endtask

  task automatic compare_frames(input string tag, input logic [7:0] got[$]);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad_gap;
    int g;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(a_m_tdata), 32'd0);
    check("rst_underrun", 32'(a_underrun), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_s_tready", 32'(a_s_tready), 32'd0);
    check("rst_crc", u_a.r_crc, 32'hFFFF_FFFF);
    check("rst_cnt", 32'(u_a.r_cnt), 32'd0);
    check("rst_pace", 32'(u_a.r_pace), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // "123456789" without padding: known check value 0xCBF43926
    frm_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    send_frame(1, -1);
    wait_idle(1, "np");
    compare_frames("np", b_got_q);
    bad_gap = 0;
    for (int i = 1; i < b_tim_q.size(); i++) begin
      if (b_tim_q[i] - b_tim_q[i-1] != CPB) bad_gap++;
    end
    check("np_spacing", 32'(bad_gap), 32'd0);
    check("np_underrun", 32'(b_under_cnt), 32'd0);

    // 1-byte frame padded to 60
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    frm_q = '{8'hAA};
    add_expected(60, -1);
    send_frame(0, -1);
    wait_idle(0, "pad1");
    compare_frames("pad1", a_got_q);

    // 64-byte frame followed immediately by a second frame
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    make_frame(64);
    add_expected(60, -1);
    send_frame(0, -1);
    make_frame(10);
    add_expected(60, -1);
    send_frame(0, -1);
    wait_idle(0, "b2b");
    compare_frames("b2b", a_got_q);
    if (a_tim_q.size() > 68) begin
      check("b2b_gap_ok", 32'((a_tim_q[68] - a_tim_q[67]) >= 13 * CPB), 32'd1);
    end

    // Input starved after byte 20
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    a_under_cnt = 0;
    make_frame(30);
    add_expected(60, 20);
    send_frame(0, 20);
    wait_idle(0, "urun");
    compare_frames("urun", a_got_q);
    check("urun_pulses", 32'(a_under_cnt), 32'd1);
    check("urun_bad_cleared", 32'(u_a.r_bad), 32'd0);

    // Downstream stall of three slots mid-frame
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    a_stab_err = 0; a_hold_cycles = 0;
    make_frame(40);
    add_expected(60, -1);
    fork
      send_frame(0, -1);
      begin
        g = 0;
        while (a_got_q.size() < 10 && g < 3000) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        a_m_tready = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        a_m_tready = 1'b1;
      end
    join
    wait_idle(0, "stall");
    compare_frames("stall", a_got_q);
    check("stall_stable", 32'(a_stab_err), 32'd0);
    check("stall_seen", 32'(a_hold_cycles > 0), 32'd1);

    // Reset asserted in the middle of DATA
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    make_frame(30);
    fork
      send_frame(0, -1);
      begin
        g = 0;
        while (a_got_q.size() < 5 && g < 3000) begin @(negedge clk); g++; end
        @(posedge clk); #2;
        abort_tx = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
        check("mid_rst_m_tdata", 32'(a_m_tdata), 32'd0);
        check("mid_rst_underrun", 32'(a_underrun), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        check("mid_rst_s_tready", 32'(a_s_tready), 32'd0);
        check("mid_rst_crc", u_a.r_crc, 32'hFFFF_FFFF);
      end
    join
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    abort_tx = 1'b0;
    repeat (2) @(posedge clk); #1;
    a_got_q.delete(); a_tim_q.delete(); exp_q.delete();
    make_frame(10);
    add_expected(60, -1);
    send_frame(0, -1);
    wait_idle(0, "post_rst");
    compare_frames("post_rst", a_got_q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sakebi_eth_frame_tx.md
Name: sakebi_eth_frame_tx

Overview:
- Framing stage directly upstream of the RMII transmitter.
- Accepts raw Ethernet frame bytes (DA..payload, delimited by TLAST) on an AXI-Stream slave. Pads short frames, appends the IEEE 802.3 CRC-32 FCS, and paces the output bytes to the RMII line rate.
- The RMII transmitter ends a frame when its FIFO runs empty, so this block must deliver every byte of a frame at exactly one byte per line-byte period, with no holes. It then enforces an inter-frame gap.

Parameters:
- DATA_WIDTH, 8, byte width; only 8 is supported.
- CYCLES_PER_BYTE, 8, i_axis_ACLK cycles per line byte slot; 8 corresponds to a 100 MHz ACLK driving a 100 Mb/s RMII line. Must be >= 2.
- MIN_LEN, 60, minimum frame length in bytes before FCS; shorter frames are zero-padded. 0 disables padding.
- IFG_BYTES, 12, idle byte slots inserted after each FCS.

Ports:
- i_axis_ACLK  in  1  clock.
- i_axis_ARESETn  in  1  asynchronous active-low reset.
- i_s_axis_TVALID  in  1  input byte valid.
- o_s_axis_TREADY  out  1  input byte accepted (combinational).
- i_s_axis_TDATA  in  DATA_WIDTH  input byte.
- i_s_axis_TLAST  in  1  last byte of frame.
- o_m_axis_TVALID  out  1  output byte valid (registered).
- i_m_axis_TREADY  in  1  downstream accept.
- o_m_axis_TDATA  out  DATA_WIDTH  output byte (registered).
- o_underrun  out  1  one-cycle pulse: input starved mid-frame.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; pace counter 0; CRC register 0xFFFFFFFF; byte count 0.
- Pace counter: counts 0..CYCLES_PER_BYTE-1 and wraps.
- slot = (pace==CYCLES_PER_BYTE-1) && (!o_m_axis_TVALID || i_m_axis_TREADY). At terminal count with slot false, pace holds until slot is true.
- Output handshake: o_m_axis_TVALID clears on the cycle after acceptance unless a new byte is loaded in the same cycle. o_m_axis_TDATA is stable while TVALID=1 and TREADY=0.
- States: IDLE, DATA, PAD, FCS, DISCARD, IFG.
- IDLE: pace counter held at 0.
  - On i_s_axis_TVALID=1: go to DATA, pace starts at 0. The first byte is consumed at the first slot, CYCLES_PER_BYTE-1 cycles after entry.
- DATA: o_s_axis_TREADY = slot && i_s_axis_TVALID.
  - On each accepted byte: load output register, update CRC, increment byte count. Byte count is 11 bits and saturates at 2047.
  - Accepted byte with TLAST=1: go to PAD if count < MIN_LEN after that byte, else FCS.
  - slot with i_s_axis_TVALID=0 (underrun): pulse o_underrun and go to FCS with the bad flag set. That slot emits nothing.
- PAD: at each slot, emit 0x00, update CRC, increment count. On reaching MIN_LEN, go to FCS.
- FCS: fcs = ~crc.
  - Emit fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24] on 4 consecutive slots.
  - With the bad flag set, emit ~fcs instead so the receiver drops the frame.
  - After the 4th byte: go to DISCARD if bad, else IFG.
  - Reinitialise CRC to 0xFFFFFFFF and count to 0.
- DISCARD: o_s_axis_TREADY=1. Input bytes are dropped until a beat with TVALID && TLAST, then go to IFG and clear the bad flag.
- IFG: count IFG_BYTES slots with no output, then go to IDLE.
- CRC-32: reflected, poly 0xEDB88320, init 0xFFFFFFFF, byte-wise update per emitted data/pad byte, computed in one cycle.
- o_s_axis_TREADY=0 in IDLE, PAD, FCS and IFG.
- A TLAST on the very first byte of a frame is legal: a 1-byte frame is padded to MIN_LEN.
- Back-to-back frames: a frame waiting during IFG is not accepted until IDLE. Minimum spacing between frames is IFG_BYTES+1 slots.
- Downstream stall (i_m_axis_TREADY=0) delays slots. The downstream stage must not stall mid-frame in normal operation.

Test Plan:
- MIN_LEN=0, frame "123456789" (0x31..0x39, TLAST on 0x39), TREADY=1:
  - Output 0x31..0x39 then 0x26 0x39 0xF4 0xCB.
  - Output TVALID pulses exactly CYCLES_PER_BYTE cycles apart; o_underrun never asserted.
- MIN_LEN=60, 1-byte frame 0xAA:
  - 1 + 59 zero bytes, then 4 FCS bytes matching the bench CRC model; 64 output beats total.
- 64-byte frame, MIN_LEN=60: no padding; 68 output beats.
  - A second frame presented immediately: its first output byte appears no earlier than 13 slots after the last FCS byte.
- Drop i_s_axis_TVALID for one slot after byte 20:
  - o_underrun pulses once; 20 data bytes then the complemented FCS.
  - Remaining input bytes up to TLAST are consumed with no output; block returns to IDLE after IFG.
- Hold i_m_axis_TREADY=0 for 3 slots mid-frame:
  - o_m_axis_TDATA stable and no byte lost or duplicated; FCS still correct.
- Assert i_axis_ARESETn=0 mid-DATA:
  - All outputs 0 immediately; the next frame after release is emitted with correct FCS.
